// File: rtl/cfi_shadow_stack_if.sv
// CFI log / fault bus between the CFI FIFO read side, the core and the shadow stack backend.
interface cfi_shadow_stack_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 64
);
  localparam int unsigned PW = $clog2(DEPTH + 1);

  logic            queue_empty_i;
  logic [1:0]      log_kind_i;
  logic [XLEN-1:0] log_pc_i;
  logic [XLEN-1:0] log_target_i;
  logic            log_rvc_i;
  logic            queue_pop_o;
  logic            clear_i;
  logic            fault_ack_i;
  logic            fault_valid_o;
  logic [1:0]      fault_cause_o;
  logic [XLEN-1:0] fault_tval_o;
  logic [PW-1:0]   depth_o;

  // Backend side
  modport slave (
    input  queue_empty_i, log_kind_i, log_pc_i, log_target_i, log_rvc_i,
    input  clear_i, fault_ack_i,
    output queue_pop_o, fault_valid_o, fault_cause_o, fault_tval_o, depth_o
  );

  // FIFO / core side
  modport master (
    output queue_empty_i, log_kind_i, log_pc_i, log_target_i, log_rvc_i,
    output clear_i, fault_ack_i,
    input  queue_pop_o, fault_valid_o, fault_cause_o, fault_tval_o, depth_o
  );
endinterface

// File: rtl/cfi_shadow_stack.sv
// Return-address checking backend: pops one CFI log per two cycles, pushes call
// return addresses on a shadow stack and checks returns against it.
module cfi_shadow_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  cfi_shadow_stack_if.slave  bus
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH + 1);

  localparam logic [1:0] KIND_CALL = 2'b10;
  localparam logic [1:0] KIND_RET  = 2'b11;

  localparam logic [1:0] CAUSE_OVERFLOW  = 2'b01;
  localparam logic [1:0] CAUSE_UNDERFLOW = 2'b10;
  localparam logic [1:0] CAUSE_MISMATCH  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    FAULT = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0]      kind;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            rvc;
  } entry_t;

  state_e          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  entry_t          entry, entry_d;
  logic            fault_valid, fault_valid_d;
  logic [1:0]      cause, cause_d;
  logic [XLEN-1:0] tval, tval_d;
  logic            push_en;
  logic            pop_c;
  logic [XLEN-1:0] ret_addr;
  logic [XLEN-1:0] top;

  logic [XLEN-1:0] stack [DEPTH];

  // Return address of the latched call, wrapping modulo 2^XLEN
  assign ret_addr = entry.pc + (entry.rvc ? XLEN'(2) : XLEN'(4));
  // Top-of-stack; only consulted when ptr > 0
  assign top      = stack[IW'(ptr - PW'(1))];

  // State and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr         <= '0;
      entry       <= '0;
      fault_valid <= 1'b0;
      cause       <= '0;
      tval        <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      entry       <= entry_d;
      fault_valid <= fault_valid_d;
      cause       <= cause_d;
      tval        <= tval_d;
    end
  end

  // Shadow stack storage, not reset: entries at or above ptr are never read
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      stack[IW'(ptr)] <= ret_addr;
    end
  end

  // Next-state, pop strobe and stack update decisions
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    entry_d       = entry;
    fault_valid_d = fault_valid;
    cause_d       = cause;
    tval_d        = tval;
    push_en       = 1'b0;
    pop_c         = 1'b0;

    unique case (state)
      IDLE: begin
        if (!bus.queue_empty_i) begin
          pop_c   = 1'b1;
          entry_d = '{kind:   bus.log_kind_i,
                      pc:     bus.log_pc_i,
                      target: bus.log_target_i,
                      rvc:    bus.log_rvc_i};
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (entry.kind == KIND_CALL) begin
          if (ptr == PW'(DEPTH)) begin
            cause_d       = CAUSE_OVERFLOW;
            tval_d        = entry.pc;
            fault_valid_d = 1'b1;
            state_d       = FAULT;
          end else begin
            push_en = 1'b1;
            ptr_d   = ptr + PW'(1);
          end
        end else if (entry.kind == KIND_RET) begin
          if (ptr == '0) begin
            cause_d       = CAUSE_UNDERFLOW;
            tval_d        = entry.pc;
            fault_valid_d = 1'b1;
            state_d       = FAULT;
          end else if (top != entry.target) begin
            cause_d       = CAUSE_MISMATCH;
            tval_d        = entry.pc;
            fault_valid_d = 1'b1;
            state_d       = FAULT;
          end else begin
            ptr_d = ptr - PW'(1);
          end
        end
      end
      FAULT: begin
        if (bus.fault_ack_i) begin
          ptr_d         = '0;
          fault_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Context-switch clear overrides everything, dropping any latched entry
    if (bus.clear_i) begin
      state_d       = IDLE;
      ptr_d         = '0;
      fault_valid_d = 1'b0;
      cause_d       = cause;
      tval_d        = tval;
      entry_d       = entry;
      push_en       = 1'b0;
      pop_c         = 1'b0;
    end
  end

  // Pop is combinational from IDLE and suppressed while in reset
  assign bus.queue_pop_o   = pop_c & rst_ni;
  assign bus.fault_valid_o = fault_valid;
  assign bus.fault_cause_o = cause;
  assign bus.fault_tval_o  = tval;
  assign bus.depth_o       = ptr;

endmodule
